stdp_weight_update: RTL and testbench



---
 rtl/stdp_pkg.sv | 20 ++
 rtl/stdp_weight_update_if.sv | 27 ++
 rtl/stdp_weight_update_lfsr.sv | 21 ++
 rtl/stdp_weight_update.sv | 126 ++++++++++++
 tb/tb_stdp_weight_update.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stdp_pkg.sv
// Shared types and constants for the STDP LFSR-comparator learning datapath.
package stdp_pkg;

    localparam int          P_WIDTH_DEF   = 7;
    localparam int          W_WIDTH_DEF   = 3;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        APPLY = 2'd2
    } upd_state_t;

    // One right-shift step of the maximal-length 16-bit Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/stdp_weight_update_if.sv
// Request channel from the edge-case selector into the STDP weight updater.
interface stdp_weight_update_if
    import stdp_pkg::*;
#(
    parameter int P_WIDTH = P_WIDTH_DEF
) ();

    logic               req_valid;
    logic               req_ready;
    logic [P_WIDTH-1:0] prob;
    logic               inc;

    modport master (
        output req_valid,
        output prob,
        output inc,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  prob,
        input  inc,
        output req_ready
    );

endinterface

// File: rtl/stdp_weight_update_lfsr.sv
// 16-bit Galois LFSR that advances only when adv is high; shared by comparator blocks.
module lfsr16_galois
    import stdp_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (adv) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/stdp_weight_update.sv
// Stochastic STDP weight updater: LFSR draw vs prob, saturating +/-1 weight step.
// Optional hit counter output is enabled with `define STDP_HIT_CNT_EN.
module stdp_weight_update
    import stdp_pkg::*;
#(
    parameter int          P_WIDTH   = P_WIDTH_DEF,
    parameter int          W_WIDTH   = W_WIDTH_DEF,
    parameter int          W_MAX     = 7,
    parameter int          W_INIT    = 0,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    stdp_weight_update_if.slave req,
    output logic [W_WIDTH-1:0]  weight,
    output logic                upd_done,
    output logic                upd_hit
`ifdef STDP_HIT_CNT_EN
    ,
    output logic [15:0]         hit_cnt
`endif
);

    localparam logic [W_WIDTH-1:0] W_MAX_L  = W_MAX[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] W_INIT_L = W_INIT[W_WIDTH-1:0];
    localparam logic [15:0]        RND_MASK = 16'((17'd1 << P_WIDTH) - 17'd1);

    upd_state_t         state, state_nxt;
    logic               ready_c;
    logic               accept_c;
    logic               adv_c;
    logic [15:0]        lfsr_state;
    logic [P_WIDTH-1:0] prob_p0;
    logic               inc_p0;
    logic               hit_p1;

    function automatic logic [W_WIDTH-1:0] sat_step(input logic [W_WIDTH-1:0] w,
                                                     input logic              up);
        if (up) begin
            return (w < W_MAX_L) ? w + W_WIDTH'(1) : w;
        end
        return (w != '0) ? w - W_WIDTH'(1) : w;
    endfunction

    lfsr16_galois #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv_c),
        .state (lfsr_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        accept_c  = 1'b0;
        adv_c     = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (req.req_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                adv_c     = 1'b1;
                state_nxt = APPLY;
            end
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req.req_ready = ready_c;

    // p0: request capture on acceptance
    always_ff @(posedge clk) begin
        if (accept_c) begin
            prob_p0 <= req.prob;
            inc_p0  <= req.inc;
        end
    end

    // p1: compare the pre-advance LFSR low bits against the latched probability
    always_ff @(posedge clk) begin
        if (state == DRAW) begin
            hit_p1 <= (lfsr_state & RND_MASK) < 16'(prob_p0);
        end
    end

    // p2: weight step and retirement flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight   <= W_INIT_L;
            upd_done <= 1'b0;
            upd_hit  <= 1'b0;
        end else begin
            upd_done <= (state == APPLY);
            upd_hit  <= (state == APPLY) && hit_p1;
            if ((state == APPLY) && hit_p1) begin
                weight <= sat_step(weight, inc_p0);
            end
        end
    end

`ifdef STDP_HIT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= 16'h0000;
        end else if (upd_done && upd_hit) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stdp_weight_update.sv
// Randomised bench for stdp_weight_update against an arithmetic STDP reference model.
module tb_stdp_weight_update;

    logic       clk;
    logic       rst_n;
    logic [2:0] weight;
    logic       upd_done;
    logic       upd_hit;
`ifdef STDP_HIT_CNT_EN
    logic [15:0] hit_cnt;
`endif

    int total;
    int bad;

    // reference model state
    int m_lfsr;
    int m_w;
    int m_hits;

    stdp_weight_update_if #(.P_WIDTH(7)) bus ();

    stdp_weight_update dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus),
        .weight   (weight),
        .upd_done (upd_done),
        .upd_hit  (upd_hit)
`ifdef STDP_HIT_CNT_EN
        ,
        .hit_cnt  (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_lfsr = 'hACE1;
        m_w    = 0;
        m_hits = 0;
    endfunction

    // One request: random value is the low 7 bits of the register before it steps.
    function automatic bit model_req(input int p, input bit up);
        int rnd;
        bit hit;
        rnd    = m_lfsr % 128;
        hit    = (rnd < p);
        m_lfsr = (m_lfsr / 2) ^ (((m_lfsr % 2) == 1) ? 'hB400 : 0);
        if (hit) begin
            m_hits = m_hits + 1;
            if (up && m_w < 7) m_w = m_w + 1;
            if (!up && m_w > 0) m_w = m_w - 1;
        end
        return hit;
    endfunction

    task automatic do_req(input int p, input bit up, output bit done, output bit hit,
                          output int lat, output int busy);
        done = 0; hit = 0; lat = 0; busy = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.prob      = 7'(p);
        bus.inc       = up;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.prob      = 7'($urandom);
        bus.inc       = 1'($urandom);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!bus.req_ready) busy++;
            if (upd_done) begin
                done = 1; hit = upd_hit; lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.prob = '0; bus.inc = 1'b0;
        model_reset();
        #2;
        total++; if (weight !== 3'd0) begin bad++; $display("FAIL reset_weight got=%0d exp=0", weight); end
        total++; if (upd_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", upd_done); end
        total++; if (upd_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b exp=0", upd_hit); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", bus.req_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", bus.req_ready); end
    endtask

    task automatic test_directed();
        bit d, h, e; int lat, busy;
        e = model_req(100, 1'b1);
        do_req(100, 1'b1, d, h, lat, busy);
        total++; if (!d || lat != 3) begin bad++; $display("FAIL first_latency got=%0d exp=3", lat); end
        total++; if (h !== 1'b1 || e != 1'b1) begin bad++; $display("FAIL first_hit got=%0b exp=1", h); end
        total++; if (weight !== 3'd1) begin bad++; $display("FAIL first_weight got=%0d exp=1", weight); end
        total++; if (busy != 2) begin bad++; $display("FAIL first_busy got=%0d exp=2", busy); end
        e = model_req(100, 1'b1);
        do_req(100, 1'b1, d, h, lat, busy);
        total++; if (!d || h !== 1'b0 || e != 1'b0) begin bad++; $display("FAIL second_hit got=%0b exp=0", h); end
        total++; if (weight !== 3'd1) begin bad++; $display("FAIL second_weight got=%0d exp=1", weight); end
`ifdef STDP_HIT_CNT_EN
        @(negedge clk);
        total++; if (hit_cnt !== 16'd1) begin bad++; $display("FAIL hit_cnt_two got=%0d exp=1", hit_cnt); end
`endif
    endtask

    task automatic test_prob_zero();
        bit d, h, e; int lat, busy, dones, w0;
        dones = 0;
        w0 = m_w;
        for (int n = 0; n < 50; n++) begin
            e = model_req(0, 1'b1);
            do_req(0, 1'b1, d, h, lat, busy);
            if (d) dones++;
            total++;
            if (h !== 1'b0 || e || weight !== 3'(w0) || busy != 2 || lat != 3) begin
                bad++;
                $display("FAIL prob_zero[%0d] hit=%0b w=%0d busy=%0d lat=%0d exp hit=0 w=%0d busy=2 lat=3",
                         n, h, weight, busy, lat, w0);
            end
        end
        total++; if (dones != 50) begin bad++; $display("FAIL prob_zero_dones got=%0d exp=50", dones); end
    endtask

    task automatic test_saturation();
        bit d, h, e; int lat, busy;
        for (int n = 0; n < 30; n++) begin
            e = model_req(127, 1'b1);
            do_req(127, 1'b1, d, h, lat, busy);
            total++;
            if (!d || h !== e || weight !== 3'(m_w)) begin
                bad++; $display("FAIL sat_up[%0d] hit=%0b w=%0d exp hit=%0b w=%0d", n, h, weight, e, m_w);
            end
        end
        total++; if (weight !== 3'd7) begin bad++; $display("FAIL sat_top got=%0d exp=7", weight); end
        for (int n = 0; n < 30; n++) begin
            e = model_req(127, 1'b0);
            do_req(127, 1'b0, d, h, lat, busy);
            total++;
            if (!d || h !== e || weight !== 3'(m_w)) begin
                bad++; $display("FAIL sat_dn[%0d] hit=%0b w=%0d exp hit=%0b w=%0d", n, h, weight, e, m_w);
            end
        end
        total++; if (weight !== 3'd0) begin bad++; $display("FAIL sat_bottom got=%0d exp=0", weight); end
    endtask

    task automatic test_random();
        bit d, h, e, up; int lat, busy, p;
        for (int n = 0; n < 40; n++) begin
            p  = $urandom_range(0, 127);
            up = 1'($urandom);
            e  = model_req(p, up);
            do_req(p, up, d, h, lat, busy);
            total++;
            if (!d || lat != 3 || h !== e || weight !== 3'(m_w)) begin
                bad++; $display("FAIL random[%0d] p=%0d inc=%0b hit=%0b w=%0d lat=%0d exp hit=%0b w=%0d lat=3",
                                n, p, up, h, weight, lat, e, m_w);
            end
        end
`ifdef STDP_HIT_CNT_EN
        @(negedge clk);
        total++; if (hit_cnt !== 16'(m_hits)) begin bad++; $display("FAIL hit_cnt_random got=%0d exp=%0d", hit_cnt, m_hits); end
`endif
    endtask

    task automatic test_back_to_back();
        bit exp_hit[$];
        int exp_w[$];
        int issued, dones, cyc, last_done, p;
        bit up, eh;
        int ew;
        issued = 0; dones = 0; cyc = 0; last_done = -1;
        @(negedge clk);
        while (dones < 8 && cyc < 100) begin
            if (upd_done) begin
                eh = (exp_hit.size() > 0) ? exp_hit.pop_front() : 1'b0;
                ew = (exp_w.size() > 0) ? exp_w.pop_front() : -1;
                total++;
                if (upd_hit !== eh || weight !== 3'(ew)) begin
                    bad++; $display("FAIL b2b_result[%0d] hit=%0b w=%0d exp hit=%0b w=%0d", dones, upd_hit, weight, eh, ew);
                end
                if (last_done >= 0) begin
                    total++;
                    if (cyc - last_done != 3) begin
                        bad++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - last_done);
                    end
                end
                last_done = cyc;
                dones++;
            end
            if (issued < 8 && bus.req_ready) begin
                p  = $urandom_range(0, 127);
                up = 1'($urandom);
                bus.req_valid = 1'b1; bus.prob = 7'(p); bus.inc = up;
                exp_hit.push_back(model_req(p, up));
                exp_w.push_back(m_w);
                issued++;
            end else if (issued < 8) begin
                bus.req_valid = 1'b1; bus.prob = 7'($urandom); bus.inc = 1'($urandom);
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = 1'b0;
        total++; if (dones != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", dones); end
    endtask

    task automatic test_reset_mid();
        bit d, h, e, seen; int lat, busy;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.prob = 7'd98; bus.inc = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (weight !== 3'd0) begin bad++; $display("FAIL mid_reset_weight got=%0d exp=0", weight); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%0b exp=1", bus.req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (upd_done) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_reset_no_done got=1 exp=0"); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready_after got=%0b exp=1", bus.req_ready); end
`ifdef STDP_HIT_CNT_EN
        total++; if (hit_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset_hit_cnt got=%0d exp=0", hit_cnt); end
`endif
        // rnd restarts at 97: prob 98 must hit, then after another reset prob 97 must miss
        e = model_req(98, 1'b1);
        do_req(98, 1'b1, d, h, lat, busy);
        total++; if (!d || h !== 1'b1 || e != 1'b1) begin bad++; $display("FAIL replay_hit got=%0b exp=1", h); end
        total++; if (weight !== 3'd1) begin bad++; $display("FAIL replay_weight got=%0d exp=1", weight); end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        e = model_req(97, 1'b1);
        do_req(97, 1'b1, d, h, lat, busy);
        total++; if (!d || h !== 1'b0 || e != 1'b0) begin bad++; $display("FAIL replay_edge got=%0b exp=0", h); end
        total++; if (weight !== 3'd0) begin bad++; $display("FAIL replay_edge_weight got=%0d exp=0", weight); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_prob_zero();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
